uart_rx_deser: RTL
==================

Name: uart_rx_deser

Overview:
UART receive deserializer that sits directly upstream of the receive FIFO. It oversamples the asynchronous RXi line and reassembles frames: start bit, DATA_BITS data bits LSB first, optional parity, one stop bit. Each good byte is written into the FIFO with a single-cycle write strobe. It also reports framing, parity and overrun errors to the status logic.

Parameters:
CLK_FREQ, 32_000_000, system clock frequency in Hz
BAUD_RATE, 250_000, line rate in bit/s
OVERSAMPLE, 16, ticks per bit; even, >= 8
DATA_BITS, 8, data bits per frame (5..8)
PARITY, 0, 0 = none, 1 = odd, 2 = even

Ports:
CLKip  in  1  system clock, rising edge
RSTNi  in  1  reset; asynchronous, active-low
RXi  in  1  serial line, asynchronous to CLKip, idle high
FULLi  in  1  FIFO full flag (FULLo of the downstream FIFO)
DATAo  out  DATA_BITS  received byte; drives FIFO DATAi
WEo  out  1  one-cycle write strobe; drives FIFO WEi
FRAME_ERRo  out  1  one-cycle pulse: stop bit sampled low
PARITY_ERRo  out  1  one-cycle pulse, coincident with WEo: parity mismatch
OVERRUNo  out  1  one-cycle pulse: byte dropped because FULLi = 1
BUSYo  out  1  high while the FSM is not in IDLE

Behaviour:
- Reset (RSTNi = 0):
  - All outputs are 0; DATAo is 0.
  - FSM goes to IDLE.
  - The 2-flop RXi synchroniser resets to 1.
  - The armed flag clears.
  - A partial frame is discarded.
- Baud tick:
  - DIV = round(CLK_FREQ / (BAUD_RATE * OVERSAMPLE)), minimum 1.
  - The tick counter runs 0..DIV-1 and emits a tick at DIV-1.
  - The counter is cleared on start-edge detection so sampling phase aligns to the edge.
- Arming:
  - After reset, the synchronised line must be high for OVERSAMPLE consecutive ticks before the block arms.
  - Start detection is ignored until armed.
  - This rejects a reset released mid-frame.
- Sampling:
  - The sample counter s runs 0..OVERSAMPLE-1 on ticks.
  - The line is sampled at s = OS/2-1, OS/2 and OS/2+1.
  - Bit value is the majority of the 3 samples, decided at s = OS/2+1.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE -> START: armed and synchronised falling edge (previous 1, current 0).
  - START: majority 1 means false start; return to IDLE, no strobe, no error. Majority 0 means advance at s = OS-1.
  - DATA: shift bits LSB first into a DATA_BITS register. After bit DATA_BITS-1 reaches s = OS-1, go to PAR if PARITY != 0, else STOP.
  - PAR: capture the parity bit and compare.
    - Even parity: XOR of data and parity bit must be 0.
    - Odd parity: XOR of data and parity bit must be 1.
  - STOP: at the decision tick, return to IDLE immediately, not at end of bit, so a back-to-back start edge is caught.
- Outputs, registered on the cycle after the stop decision:
  - Stop = 0: FRAME_ERRo pulses; WEo stays 0; DATAo is unchanged.
  - Stop = 1 and FULLi = 0: DATAo is loaded, WEo pulses, and PARITY_ERRo pulses in the same cycle if a mismatch occurred. A byte with a parity error is still written.
  - Stop = 1 and FULLi = 1: WEo stays 0 and OVERRUNo pulses. DATAo is still loaded.
- DATAo holds its value until the next load; WEo is never high for 2 consecutive cycles.
- Latency, from the RXi falling edge to WEo:
  - 2 synchroniser cycles + 1 edge-detect cycle.
  - Plus (1 + DATA_BITS + (PARITY != 0)) * OVERSAMPLE * DIV cycles.
  - Plus (OS/2 + 2) * DIV cycles.
  - Plus 1 cycle.
  - Tolerance is ±DIV cycles.
- A break (line held low) gives one FRAME_ERRo. The block does not re-arm via IDLE until the line goes high; re-arm requires a rising edge back to 1.

Decomposition:
- Package uart_pkg holds:
  - parity_e enum (PAR_NONE, PAR_ODD, PAR_EVEN).
  - rx_state_e enum.
  - Function calc_div(clk, baud, os).
- Sub-module uart_baud_tick: tick counter with DIV parameter, synchronous clear input and TICKo output. It is reused later by the transmitter.

Test Plan:
All scenarios use the defaults: DIV = 8, 128 clocks per bit.
1. 8N1 frame 0xA5, stop = 1, FULLi = 0 -> exactly one WEo with DATAo = 0xA5; no error pulses; BUSYo falls at the stop decision.
2. RXi low for 40 clocks, then high -> START false-start path; no WEo and no errors; BUSYo high for < 128 cycles.
3. Frame 0x3C with stop bit driven 0 -> FRAME_ERRo single pulse; WEo = 0; DATAo keeps its previous value.
4. PARITY = 2, frame 0x07 with parity bit 0 -> WEo with DATAo = 0x07 and PARITY_ERRo in the same cycle. Repeat with parity 1 -> no PARITY_ERRo.
5. FULLi = 1 during frame 0x55 -> WEo = 0 and OVERRUNo pulses. Then FULLi = 0 and frames 0x00 and 0xFF back-to-back with no idle gap -> two WEo strobes, 0x00 then 0xFF.
6. RSTNi asserted mid-data-bit of 0x5A, then released with RXi low -> no WEo and no errors. RXi high for 1 bit, then frame 0x81 -> WEo with DATAo = 0x81.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive and transmit paths.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } rx_state_e;

    // Rounded clocks-per-oversample-tick, never below 1.
    function automatic int unsigned calc_div(input int unsigned clk,
                                             input int unsigned baud,
                                             input int unsigned os);
        longint unsigned den;
        longint unsigned q;
        den = 64'(baud) * 64'(os);
        q   = (64'(clk) + den / 2) / den;
        if (q == 0) return 1;
        return 32'(q);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..DIV-1 and pulses TICKo on the last count.
module uart_baud_tick #(
    parameter int unsigned DIV = 8
) (
    input  logic CLKip,
    input  logic RSTNi,
    input  logic CLRi,
    output logic TICKo
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (CLRi || cnt_q == LAST) cnt_d = '0;
    end

    always_ff @(posedge CLKip or negedge RSTNi) begin
        if (!RSTNi) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // A clear restarts the phase, so no tick is allowed in that cycle.
    assign TICKo = (cnt_q == LAST) && !CLRi;

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: oversampled start/data/parity/stop framing feeding the RX FIFO.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 32_000_000,
    parameter int unsigned BAUD_RATE  = 250_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0
) (
    input  logic                 CLKip,
    input  logic                 RSTNi,
    input  logic                 RXi,
    input  logic                 FULLi,
    output logic [DATA_BITS-1:0] DATAo,
    output logic                 WEo,
    output logic                 FRAME_ERRo,
    output logic                 PARITY_ERRo,
    output logic                 OVERRUNo,
    output logic                 BUSYo
);

    localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int unsigned SW  = $clog2(OVERSAMPLE);
    localparam int unsigned AW  = $clog2(OVERSAMPLE + 1);
    localparam int unsigned BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SW-1:0] S_LO   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [AW-1:0] A_LAST = AW'(OVERSAMPLE - 1);
    localparam parity_e       PAR_MODE = parity_e'(PARITY[1:0]);

    logic [1:0]           sync_q;
    logic                 rx_s, rx_prev_q;
    logic                 armed_q, armed_d;
    logic [AW-1:0]        arm_cnt_q, arm_cnt_d;
    logic                 tick, start_det, decide, bit_end, maj;
    rx_state_e            state_q, state_d;
    logic [SW-1:0]        s_q, s_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           smp_q, smp_d;
    logic                 par_err_q, par_err_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 we_q, we_d, fe_q, fe_d, pe_q, pe_d, ov_q, ov_d;

    assign rx_s      = sync_q[1];
    assign start_det = (state_q == StIdle) && armed_q && rx_prev_q && !rx_s;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_tick (
        .CLKip(CLKip),
        .RSTNi(RSTNi),
        .CLRi (start_det),
        .TICKo(tick)
    );

    // Arm only after a full bit time of idle line, so a mid-frame reset release is ignored.
    always_comb begin
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q;
        if (!rx_s) begin
            arm_cnt_d = '0;
        end else if (tick && !armed_q) begin
            arm_cnt_d = arm_cnt_q + 1'b1;
            if (arm_cnt_q == A_LAST) armed_d = 1'b1;
        end
    end

    assign decide  = tick && (s_q == S_HI);
    assign bit_end = tick && (s_q == S_LAST);
    assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        smp_d     = smp_q;
        par_err_d = par_err_q;
        data_d    = data_q;
        we_d      = 1'b0;
        fe_d      = 1'b0;
        pe_d      = 1'b0;
        ov_d      = 1'b0;

        if (start_det) begin
            s_d = '0;
        end else if (tick) begin
            s_d = bit_end ? '0 : s_q + 1'b1;
            if (s_q == S_LO)  smp_d[0] = rx_s;
            if (s_q == S_MID) smp_d[1] = rx_s;
        end

        unique case (state_q)
            StIdle: begin
                if (start_det) begin
                    state_d   = StStart;
                    par_err_d = 1'b0;
                end
            end
            StStart: begin
                if (decide && maj) begin
                    state_d = StIdle;
                end else if (bit_end) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bit_q == B_LAST) state_d = (PAR_MODE != PAR_NONE) ? StPar : StStop;
                    else                 bit_d   = bit_q + 1'b1;
                end
            end
            StPar: begin
                if (decide) begin
                    par_err_d = (PAR_MODE == PAR_EVEN) ? (^shift_q ^ maj) : ~(^shift_q ^ maj);
                end
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                // Leave at the decision tick so a back-to-back start edge is not missed.
                if (decide) begin
                    state_d = StIdle;
                    if (!maj) begin
                        fe_d = 1'b1;
                    end else begin
                        data_d = shift_q;
                        if (FULLi) begin
                            ov_d = 1'b1;
                        end else begin
                            we_d = 1'b1;
                            pe_d = par_err_q;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLKip or negedge RSTNi) begin
        if (!RSTNi) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            armed_q   <= 1'b0;
            arm_cnt_q <= '0;
            state_q   <= StIdle;
            s_q       <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            smp_q     <= '0;
            par_err_q <= 1'b0;
            data_q    <= '0;
            we_q      <= 1'b0;
            fe_q      <= 1'b0;
            pe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], RXi};
            rx_prev_q <= rx_s;
            armed_q   <= armed_d;
            arm_cnt_q <= arm_cnt_d;
            state_q   <= state_d;
            s_q       <= s_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            smp_q     <= smp_d;
            par_err_q <= par_err_d;
            data_q    <= data_d;
            we_q      <= we_d;
            fe_q      <= fe_d;
            pe_q      <= pe_d;
            ov_q      <= ov_d;
        end
    end

    assign DATAo       = data_q;
    assign WEo         = we_q;
    assign FRAME_ERRo  = fe_q;
    assign PARITY_ERRo = pe_q;
    assign OVERRUNo    = ov_q;
    assign BUSYo       = (state_q != StIdle);

endmodule
